// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter for a 1K x 16 RAM with bounded burst lock.
// M0 is the CPU bus, M1 the DMA/loader engine.
module ram_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic          i_m0_lock,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_gnt,
    output logic          o_m0_rvalid,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic          i_m1_lock,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_gnt,
    output logic          o_m1_rvalid,
    output logic [DW-1:0] o_m1_rdata,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_waddr,
    output logic [AW-1:0] o_ram_raddr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata,
    output logic          o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    logic [1:0] state, state_nx;
    logic       rr, rr_nx;
    logic [7:0] cnt, cnt_nx, cnt_inc;
    logic       gnt0, gnt1;
    logic       g0, g1;
    logic       wr0, wr1, rd0, rd1;
    logic       rvalid0, rvalid1;

    assign cnt_inc = (cnt >= LOCK_MAX) ? LOCK_MAX : cnt + 8'd1;

    // rr = 1 means M1 wins a tie in IDLE
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        state_nx = state;
        rr_nx    = rr;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (i_m0_req && (!i_m1_req || !rr)) gnt0 = 1'b1;
                else if (i_m1_req)                   gnt1 = 1'b1;
            end
            OWN0: begin
                if (cnt == LOCK_MAX && i_m1_req) begin
                    state_nx = IDLE;
                    rr_nx    = 1'b1;
                end else if (i_m0_req) begin
                    gnt0 = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            OWN1: begin
                if (cnt == LOCK_MAX && i_m0_req) begin
                    state_nx = IDLE;
                    rr_nx    = 1'b0;
                end else if (i_m1_req) begin
                    gnt1 = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (gnt0) begin
            rr_nx = 1'b1;
            if (i_m0_lock) begin
                state_nx = OWN0;
                cnt_nx   = (state == OWN0) ? cnt_inc : 8'd1;
            end else begin
                state_nx = IDLE;
            end
        end
        if (gnt1) begin
            rr_nx = 1'b0;
            if (i_m1_lock) begin
                state_nx = OWN1;
                cnt_nx   = (state == OWN1) ? cnt_inc : 8'd1;
            end else begin
                state_nx = IDLE;
            end
        end
        if (state_nx == IDLE) cnt_nx = 8'd0;
    end

    // Grants are masked while reset is held
    assign g0  = gnt0 & i_reset;
    assign g1  = gnt1 & i_reset;
    assign wr0 = g0 & i_m0_we;
    assign wr1 = g1 & i_m1_we;
    assign rd0 = g0 & ~i_m0_we;
    assign rd1 = g1 & ~i_m1_we;

    assign o_m0_gnt    = g0;
    assign o_m1_gnt    = g1;
    assign o_ram_we    = wr0 | wr1;
    assign o_ram_waddr = wr0 ? i_m0_addr  : (wr1 ? i_m1_addr  : '0);
    assign o_ram_wdata = wr0 ? i_m0_wdata : (wr1 ? i_m1_wdata : '0);
    assign o_ram_raddr = rd0 ? i_m0_addr  : (rd1 ? i_m1_addr  : '0);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            rr      <= 1'b0;
            cnt     <= 8'd0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            state   <= state_nx;
            rr      <= rr_nx;
            cnt     <= cnt_nx;
            rvalid0 <= rd0;
            rvalid1 <= rd1;
        end
    end

    assign o_m0_rvalid = rvalid0;
    assign o_m1_rvalid = rvalid1;
    assign o_m0_rdata  = rvalid0 ? i_ram_rdata : '0;
    assign o_m1_rdata  = rvalid1 ? i_ram_rdata : '0;
    assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic,
// checked against an ownership-level model and a shadow memory.
module tb_ram_arbiter;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock;
    logic [9:0]  m0_addr;
    logic [15:0] m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [9:0]  m1_addr;
    logic [15:0] m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic        ram_we, busy;
    logic [9:0]  ram_waddr, ram_raddr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(10), .DW(16), .MAX_LOCK(MAXL)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_lock(m0_lock),
        .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_lock(m1_lock),
        .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_ram_we(ram_we), .o_ram_waddr(ram_waddr), .o_ram_raddr(ram_raddr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_busy(busy)
    );

    // Synchronous read-before-write RAM
    bit [15:0] mem [1024];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    int ntot = 0;
    int npass = 0;

    int        owner = -1;
    int        run = 0;
    int        pref = 0;
    int        lastwin = -1;
    bit [15:0] shadow [1024];
    bit        erv [2];
    logic [15:0] erd [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set0(input logic r, input logic w, input logic l,
                        input logic [9:0] a, input logic [15:0] d);
        m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l,
                        input logic [9:0] a, input logic [15:0] d);
        m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
    endtask

    // One cycle: predict, compare, advance the model, wait for next negedge
    task automatic tick();
        int          win;
        int          nowner;
        logic        rq [2];
        logic        wr [2];
        logic        lk [2];
        logic [9:0]  ad [2];
        logic [15:0] wd [2];
        bit          nrv [2];
        logic [15:0] nrd [2];
        #1;
        rq = '{m0_req, m1_req};
        wr = '{m0_we, m1_we};
        lk = '{m0_lock, m1_lock};
        ad = '{m0_addr, m1_addr};
        wd = '{m0_wdata, m1_wdata};
        nrv = '{1'b0, 1'b0};
        nrd = '{16'h0, 16'h0};
        win = -1;
        nowner = owner;
        if (!rst_n) begin
            owner = -1; run = 0; pref = 0; nowner = -1;
            erv = '{1'b0, 1'b0};
        end else if (owner < 0) begin
            if (rq[0] && rq[1]) win = pref;
            else if (rq[0])     win = 0;
            else if (rq[1])     win = 1;
        end else if (run >= MAXL && rq[1-owner]) begin
            nowner = -1;
            pref = 1 - owner;
        end else if (rq[owner]) begin
            win = owner;
        end else begin
            nowner = -1;
        end
        chk("gnt0", 32'(m0_gnt), 32'(win == 0));
        chk("gnt1", 32'(m1_gnt), 32'(win == 1));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("rvalid0", 32'(m0_rvalid), 32'(erv[0]));
        chk("rvalid1", 32'(m1_rvalid), 32'(erv[1]));
        chk("rdata0", 32'(m0_rdata), 32'(erv[0] ? erd[0] : 16'h0));
        chk("rdata1", 32'(m1_rdata), 32'(erv[1] ? erd[1] : 16'h0));
        if (win >= 0 && wr[win]) begin
            chk("ram_we", 32'(ram_we), 32'd1);
            chk("waddr", 32'(ram_waddr), 32'(ad[win]));
            chk("wdata", 32'(ram_wdata), 32'(wd[win]));
            shadow[ad[win]] = wd[win];
        end else if (win >= 0) begin
            chk("ram_we_rd", 32'(ram_we), 32'd0);
            chk("raddr", 32'(ram_raddr), 32'(ad[win]));
            nrv[win] = 1'b1;
            nrd[win] = shadow[ad[win]];
        end else begin
            chk("idle_we", 32'(ram_we), 32'd0);
            chk("idle_waddr", 32'(ram_waddr), 32'd0);
            chk("idle_wdata", 32'(ram_wdata), 32'd0);
            chk("idle_raddr", 32'(ram_raddr), 32'd0);
        end
        if (win >= 0) begin
            if (lk[win]) begin
                run = (owner == win) ? ((run < MAXL) ? run + 1 : MAXL) : 1;
                nowner = win;
            end else begin
                nowner = -1;
            end
            pref = 1 - win;
        end
        owner = nowner;
        erv = nrv;
        erd = nrd;
        lastwin = win;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set0(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        set1(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        erv = '{1'b0, 1'b0};
        erd = '{16'h0, 16'h0};
        @(negedge clk);
        set0(1'b1, 1'b1, 1'b0, 10'h001, 16'hDEAD);
        #1 chk("rst_gnt0", 32'(m0_gnt), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        tick();
        set0(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick();
        rst_n = 1'b1;

        // M0 write then read back
        set0(1'b1, 1'b1, 1'b0, 10'h005, 16'h1234);
        #1 chk("t1_wgnt", 32'(m0_gnt), 32'd1);
        tick();
        set0(1'b1, 1'b0, 1'b0, 10'h005, 16'h0);
        #1 chk("t1_rgnt", 32'(m0_gnt), 32'd1);
        tick();
        set0(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        #1 chk("t1_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t1_rdata", 32'(m0_rdata), 32'h1234);
        tick();

        // Alternation from reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 10'h010, 16'h0);
        set1(1'b1, 1'b0, 1'b0, 10'h020, 16'h0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_gnt0", 32'(m0_gnt), 32'(i % 2 == 0));
            chk("t2_gnt1", 32'(m1_gnt), 32'(i % 2 == 1));
            tick();
        end
        set1(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick();

        // M1 locked burst blocks M0
        set0(1'b1, 1'b0, 1'b0, 10'h040, 16'h0);
        for (int i = 0; i < 4; i++) begin
            set1(1'b1, 1'b1, 1'(i < 3), 10'(10'h100 + i), 16'(16'hA000 + i));
            #1 chk("t3_gnt0", 32'(m0_gnt), 32'd0);
            chk("t3_gnt1", 32'(m1_gnt), 32'd1);
            if (i > 0) chk("t3_busy", 32'(busy), 32'd1);
            tick();
        end
        set1(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        #1 chk("t3_gnt0_5th", 32'(m0_gnt), 32'd1);
        tick();
        set0(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick();

        // Forced release after MAX_LOCK grants
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 1'b1, 10'h050, 16'h0);
        set1(1'b1, 1'b0, 1'b0, 10'h060, 16'h0);
        for (int i = 0; i < 6; i++) begin
            #1 chk("t4_gnt0", 32'(m0_gnt), 32'(i < 4));
            chk("t4_gnt1", 32'(m1_gnt), 32'(i == 5));
            tick();
        end
        set0(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        set1(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick();

        // Reset right after an M1 read grant
        set1(1'b1, 1'b0, 1'b0, 10'h070, 16'h0);
        #1 chk("t5_gnt1", 32'(m1_gnt), 32'd1);
        tick();
        set1(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        rst_n = 1'b0;
        #1 chk("t5_rvalid1", 32'(m1_rvalid), 32'd0);
        tick();
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 10'h071, 16'h0);
        set1(1'b1, 1'b0, 1'b0, 10'h072, 16'h0);
        #1 chk("t5_pref0", 32'(m0_gnt), 32'd1);
        tick();
        set0(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick();
        set1(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        tick();

        // Read-before-write on consecutive cycles
        set0(1'b1, 1'b1, 1'b0, 10'h3FF, 16'hAAAA);
        tick();
        set0(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        set1(1'b1, 1'b0, 1'b0, 10'h3FF, 16'h0);
        tick();
        set1(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        set0(1'b1, 1'b1, 1'b0, 10'h3FF, 16'h5555);
        #1 chk("t6_rvalid1", 32'(m1_rvalid), 32'd1);
        chk("t6_old", 32'(m1_rdata), 32'hAAAA);
        tick();
        set0(1'b1, 1'b0, 1'b0, 10'h3FF, 16'h0);
        tick();
        set0(1'b0, 1'b0, 1'b0, 10'h0, 16'h0);
        #1 chk("t6_new", 32'(m0_rdata), 32'h5555);
        tick();

        // Random traffic; a pending request is held until granted
        for (int n = 0; n < 400; n++) begin
            if (!(m0_req && lastwin != 0))
                set0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
                     16'($urandom));
            if (!(m1_req && lastwin != 1))
                set1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 2) == 0), 10'($urandom_range(0, 15)),
                     16'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
